// File: rtl/bsg_gateway_chip_wh_link_monitor_if.sv
// rtl/bsg_gateway_chip_wh_link_monitor_if.sv - valid/ready_and wormhole flit link
interface bsg_gateway_chip_wh_link_monitor_if #(
    parameter int width_p = 32
) ();
    logic               v;
    logic [width_p-1:0] data;
    logic               ready_and;

    modport master (output v, output data, input  ready_and);
    modport slave  (input  v, input  data, output ready_and);
endinterface

// File: rtl/bsg_gateway_chip_wh_link_monitor.sv
// rtl/bsg_gateway_chip_wh_link_monitor.sv - two-entry wormhole flit stage with X scrub, framing tracker and counters
module bsg_gateway_chip_wh_link_monitor #(
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 7,
    parameter int len_width_p  = 4,
    parameter int max_len_p    = 8,
    parameter int ctr_width_p  = 32
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    bsg_gateway_chip_wh_link_monitor_if.slave     link_i,
    bsg_gateway_chip_wh_link_monitor_if.master    link_o,
    output logic                                  in_packet_o,
    output logic [ctr_width_p-1:0]                pkt_count_o,
    output logic [ctr_width_p-1:0]                flit_count_o,
    output logic                                  err_x_o,
    output logic                                  err_len_o
);

    typedef enum logic {
        e_header = 1'b0,
        e_body   = 1'b1
    } state_e;

    localparam logic [len_width_p-1:0] len_one_lp = len_width_p'(1);
    localparam logic [ctr_width_p-1:0] ctr_one_lp = ctr_width_p'(1);

    state_e                  state_q, state_d;
    logic [len_width_p-1:0]  remaining_q, remaining_d;
    logic [flit_width_p-1:0] mem_q [2];
    logic [flit_width_p-1:0] mem_d [2];
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              count_q, count_d;
    logic                    ready_q, ready_d;
    logic [ctr_width_p-1:0]  pkt_count_q, pkt_count_d;
    logic [ctr_width_p-1:0]  flit_count_q, flit_count_d;
    logic                    err_x_q, err_x_d;
    logic                    err_len_q, err_len_d;

    logic                    accept;
    logic                    transfer;
    logic                    pkt_done;
    logic                    has_x;
    logic [flit_width_p-1:0] scrubbed;
    logic [len_width_p-1:0]  hdr_len;

    assign accept   = link_i.v & ready_q;
    assign transfer = (count_q != 2'd0) & link_o.ready_and;
    assign hdr_len  = link_i.data[cord_width_p +: len_width_p];

    // Only a definite 1 survives; X/Z collapse to 0 and flag the flit.
    always_comb begin
        scrubbed = '0;
        has_x    = 1'b0;
        for (int i = 0; i < flit_width_p; i++) begin
            scrubbed[i] = (link_i.data[i] === 1'b1);
            has_x       = has_x | ((link_i.data[i] !== 1'b0) && (link_i.data[i] !== 1'b1));
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            mem_d[wr_ptr_q] = scrubbed;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (transfer) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({accept, transfer})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Registered ready looks at next occupancy, so it never waits on ready_and_i combinationally.
        ready_d = (count_d != 2'd2);
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pkt_done    = 1'b0;
        if (accept) begin
            case (state_q)
                e_header: begin
                    if (hdr_len == '0) begin
                        pkt_done = 1'b1;
                    end else begin
                        remaining_d = hdr_len;
                        state_d     = e_body;
                    end
                end
                e_body: begin
                    remaining_d = remaining_q - len_one_lp;
                    if (remaining_q == len_one_lp) begin
                        pkt_done = 1'b1;
                        state_d  = e_header;
                    end
                end
                default: state_d = e_header;
            endcase
        end

        pkt_count_d = pkt_count_q;
        if (pkt_done && (pkt_count_q != '1)) begin
            pkt_count_d = pkt_count_q + ctr_one_lp;
        end
        flit_count_d = flit_count_q;
        if (accept && (flit_count_q != '1)) begin
            flit_count_d = flit_count_q + ctr_one_lp;
        end

        err_x_d   = err_x_q | (accept & has_x);
        err_len_d = err_len_q | (accept && (state_q == e_header) && (int'(hdr_len) > max_len_p));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= e_header;
            remaining_q  <= '0;
            mem_q        <= '{default: '0};
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            ready_q      <= 1'b0;
            pkt_count_q  <= '0;
            flit_count_q <= '0;
            err_x_q      <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            pkt_count_q  <= pkt_count_d;
            flit_count_q <= flit_count_d;
            err_x_q      <= err_x_d;
            err_len_q    <= err_len_d;
        end
    end

    always_comb begin
        link_i.ready_and = ready_q;
        link_o.v         = (count_q != 2'd0);
        link_o.data      = mem_q[rd_ptr_q];
        in_packet_o      = (state_q == e_body);
        pkt_count_o      = pkt_count_q;
        flit_count_o     = flit_count_q;
        err_x_o          = err_x_q;
        err_len_o        = err_len_q;
    end

endmodule

// File: tb/tb_bsg_gateway_chip_wh_link_monitor.sv
// tb/tb_bsg_gateway_chip_wh_link_monitor.sv - scoreboard bench for the wormhole link monitor
module tb_bsg_gateway_chip_wh_link_monitor;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    bsg_gateway_chip_wh_link_monitor_if #(.width_p(W)) up_if ();
    bsg_gateway_chip_wh_link_monitor_if #(.width_p(W)) dn_if ();
    bsg_gateway_chip_wh_link_monitor_if #(.width_p(W)) up2_if ();
    bsg_gateway_chip_wh_link_monitor_if #(.width_p(W)) dn2_if ();

    logic        in_packet, err_x, err_len;
    logic [31:0] pkt_count, flit_count;
    logic        in_packet2, err_x2, err_len2;
    logic [3:0]  pkt_count2, flit_count2;

    bsg_gateway_chip_wh_link_monitor dut (
        .clk_i(clk), .reset_n_i(rst_n), .link_i(up_if.slave), .link_o(dn_if.master),
        .in_packet_o(in_packet), .pkt_count_o(pkt_count), .flit_count_o(flit_count),
        .err_x_o(err_x), .err_len_o(err_len)
    );

    bsg_gateway_chip_wh_link_monitor #(.ctr_width_p(4)) dut_sat (
        .clk_i(clk), .reset_n_i(rst_n), .link_i(up2_if.slave), .link_o(dn2_if.master),
        .in_packet_o(in_packet2), .pkt_count_o(pkt_count2), .flit_count_o(flit_count2),
        .err_x_o(err_x2), .err_len_o(err_len2)
    );

    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    int          exp_pkts = 0;
    int          exp_flits = 0;
    logic        exp_err_x = 1'b0;
    logic        exp_err_len = 1'b0;
    int          stall_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] scrub(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = (d[i] === 1'b1);
        return r;
    endfunction

    function automatic logic any_x(input logic [W-1:0] d);
        logic r;
        r = 1'b0;
        for (int i = 0; i < W; i++) r = r | ((d[i] !== 1'b0) && (d[i] !== 1'b1));
        return r;
    endfunction

    function automatic logic [W-1:0] hdr(input int len, input int cord);
        logic [W-1:0] h;
        logic [31:0]  l, c;
        l = len;
        c = cord;
        h = 32'hA500_0000;
        h[6:0]  = c[6:0];
        h[10:7] = l[3:0];
        return h;
    endfunction

    // Scoreboard monitor: every downstream transfer pops one expected flit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && dn_if.v && dn_if.ready_and) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit: got %0h expected none", dn_if.data);
                end else begin
                    check("data_o", dn_if.data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_flit(input logic [W-1:0] d, input logic exp_inpkt);
        int  waits;
        bit  done;
        waits = 0;
        done  = 0;
        up_if.v    = 1'b1;
        up_if.data = d;
        while (!done) begin
            @(negedge clk);
            if (up_if.ready_and) begin
                done = 1;
                check("in_packet_o", in_packet, exp_inpkt);
                exp_q.push_back(scrub(d));
                exp_flits++;
                exp_err_x = exp_err_x | any_x(d);
            end else begin
                waits++;
                stall_cycles++;
                if (waits > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
                    done = 1;
                end
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_packet(input int len, input int cord, input logic [W-1:0] body_base);
        send_flit(hdr(len, cord), 1'b0);
        if (len > 8) exp_err_len = 1'b1;
        for (int i = 0; i < len; i++) send_flit(body_base + W'(i), 1'b1);
        up_if.v = 1'b0;
        exp_pkts++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_pkt_count"}, pkt_count, 64'(exp_pkts));
        check({tag, "_flit_count"}, flit_count, 64'(exp_flits));
        check({tag, "_err_x"}, err_x, exp_err_x);
        check({tag, "_err_len"}, err_len, exp_err_len);
    endtask

    initial begin
        logic [W-1:0] h, xf;
        int acc2;

        rst_n = 1'b0;
        up_if.v = 1'b1;  up_if.data = 32'h1234_5678;
        dn_if.ready_and = 1'b1;
        up2_if.v = 1'b0; up2_if.data = '0;
        dn2_if.ready_and = 1'b1;

        // Reset / idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_and_o", up_if.ready_and, 1'b0);
        check("rst_v_o", dn_if.v, 1'b0);
        check("rst_data_o", dn_if.data, 64'd0);
        check("rst_in_packet_o", in_packet, 1'b0);
        check_status("rst");
        @(posedge clk); #2;
        up_if.v = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready_before_edge", up_if.ready_and, 1'b0);
        @(negedge clk);
        check("post_rst_ready_after_edge", up_if.ready_and, 1'b1);
        @(posedge clk); #2;

        // Streaming with downstream always ready
        stall_cycles = 0;
        send_packet(0, 5, 32'h1000_0000);
        send_packet(2, 6, 32'h2000_0000);
        send_packet(3, 7, 32'h3000_0000);
        check("stream_stalls", 64'(stall_cycles), 64'd0);
        drain();
        check("stream_pkt_count", pkt_count, 64'd3);
        check("stream_flit_count", flit_count, 64'd8);
        check_status("stream");

        // Backpressure for 5 cycles with continuous valid
        h = hdr(4, 9);
        dn_if.ready_and = 1'b0;
        fork
            send_packet(4, 9, 32'h4000_0000);
            begin
                repeat (2) @(negedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check("bp_ready_and_o", up_if.ready_and, 1'b0);
                    check("bp_v_o", dn_if.v, 1'b1);
                    check("bp_data_stable", dn_if.data, h);
                end
                check("bp_flit_count", flit_count, 64'd10);
                @(posedge clk); #2;
                dn_if.ready_and = 1'b1;
            end
        join
        drain();
        check_status("bp");

        // Over-length header is flagged but forwarded
        send_packet(9, 3, 32'h5000_0000);
        drain();
        check("len9_flit_count", flit_count, 64'd23);
        check_status("len9");

        // Body flit carrying X in bits [3:0]
        xf = 32'hC0DE_00F0;
        xf[3:0] = 4'bx;
        send_flit(hdr(2, 1), 1'b0);
        send_flit(xf, 1'b1);
        send_flit(32'h6000_0001, 1'b1);
        up_if.v = 1'b0;
        exp_pkts++;
        drain();
        check_status("xflit");
        send_packet(1, 2, 32'h6100_0000);
        drain();
        check_status("sticky");

        // Reset in the middle of a len=4 packet with flits still buffered
        dn_if.ready_and = 1'b0;
        send_flit(hdr(4, 11), 1'b0);
        send_flit(32'h7000_0000, 1'b1);
        up_if.v = 1'b0;
        check("mid_v_o_before_rst", dn_if.v, 1'b1);
        check("mid_in_packet_before_rst", in_packet, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_pkts = 0;
        exp_flits = 0;
        exp_err_x = 1'b0;
        exp_err_len = 1'b0;
        check("async_v_o", dn_if.v, 1'b0);
        check("async_data_o", dn_if.data, 64'd0);
        check("async_ready_and_o", up_if.ready_and, 1'b0);
        check("async_in_packet_o", in_packet, 1'b0);
        check_status("async");
        @(posedge clk); #2;
        rst_n = 1'b1;
        dn_if.ready_and = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        send_flit(hdr(0, 12), 1'b0);
        up_if.v = 1'b0;
        exp_pkts++;
        check("latency_v_o", dn_if.v, 1'b1);
        check("latency_data_o", dn_if.data, hdr(0, 12));
        drain();
        check_status("after_rst");
        send_packet(1, 13, 32'h8000_0000);
        drain();
        check_status("after_rst2");

        // Saturation on the 4-bit counter instance
        acc2 = 0;
        up2_if.data = hdr(0, 1);
        up2_if.v = 1'b1;
        for (int i = 0; i < 100 && acc2 < 20; i++) begin
            @(negedge clk);
            if (up2_if.ready_and) acc2++;
            @(posedge clk); #2;
        end
        up2_if.v = 1'b0;
        check("sat_accepts", 64'(acc2), 64'd20);
        repeat (2) @(posedge clk);
        #2;
        check("sat_pkt_count", pkt_count2, 64'd15);
        check("sat_flit_count", flit_count2, 64'd15);
        check("sat_err_len", err_len2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
